// File: rtl/peripheral_apb4_verilog_pkg.sv
// Shared definitions for the APB4 slave memory: FSM states, LFSR constants and a log2 helper.
package peripheral_apb4_verilog_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StWait,
    StResp
  } apb_state_e;

  localparam logic [15:0] LfsrSeed = 16'hACE1;
  // x^16 + x^14 + x^13 + x^11 + 1, as bit positions 15, 13, 12, 10
  localparam logic [15:0] LfsrTaps = 16'hB400;

  function automatic int unsigned log2_ceil(input int unsigned value);
    int unsigned result;
    result = 0;
    for (int i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(value)) result = i + 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/soc_riscv_apb_wait_gen.sv
// Wait-state generator: fixed or LFSR-derived wait count plus the down-counter that paces it.
module soc_riscv_apb_wait_gen
  import peripheral_apb4_verilog_pkg::*;
#(
  parameter int unsigned WAIT_MODE   = 0,
  parameter int unsigned WAIT_STATES = 0
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       load_i,
  input  logic       clear_i,
  output logic [3:0] n_o,
  output logic       done_o
);

  localparam logic [15:0] Modulus = 16'(WAIT_STATES + 1);

  logic [15:0] lfsr_q, lfsr_d;
  logic [3:0]  cnt_q, cnt_d;

  assign lfsr_d = {lfsr_q[14:0], ^(lfsr_q & LfsrTaps)};
  assign n_o    = (WAIT_MODE == 1) ? 4'(lfsr_q % Modulus) : 4'(WAIT_STATES);
  assign done_o = (cnt_q == 4'd1);

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (load_i) begin
      cnt_d = n_o;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - 4'd1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q  <= '0;
      lfsr_q <= LfsrSeed;
    end else begin
      cnt_q <= cnt_d;
      if (load_i) lfsr_q <= lfsr_d;
    end
  end

endmodule

// File: rtl/soc_riscv_apb_slave_mem.sv
// APB4 slave memory with byte strobes, configurable wait states and PSLVERR on
// out-of-range or secure-region violations.
module soc_riscv_apb_slave_mem
  import peripheral_apb4_verilog_pkg::*;
#(
  parameter int unsigned PADDR_SIZE   = 10,
  parameter int unsigned PDATA_SIZE   = 8,
  parameter int unsigned MEM_DEPTH    = 256,
  parameter int unsigned WAIT_MODE    = 0,
  parameter int unsigned WAIT_STATES  = 0,
  parameter int unsigned SECURE_UPPER = 0
) (
  input  logic                    PCLK,
  input  logic                    PRESET,
  input  logic                    PSEL,
  input  logic                    PENABLE,
  input  logic [2:0]              PPROT,
  input  logic                    PWRITE,
  input  logic [PDATA_SIZE/8-1:0] PSTRB,
  input  logic [PADDR_SIZE-1:0]   PADDR,
  input  logic [PDATA_SIZE-1:0]   PWDATA,
  output logic [PDATA_SIZE-1:0]   PRDATA,
  output logic                    PREADY,
  output logic                    PSLVERR
);

  localparam int unsigned StrbW   = PDATA_SIZE / 8;
  localparam int unsigned AddrLsb = log2_ceil(StrbW);
  localparam int unsigned MemAw   = log2_ceil(MEM_DEPTH);

  apb_state_e state_q, state_d;

  logic [PADDR_SIZE-1:0] idx_q;
  logic                  write_q, err_q;
  logic [StrbW-1:0]      strb_q;
  logic [PDATA_SIZE-1:0] wdata_q;

  logic                  ready_q, slverr_q;
  logic [PDATA_SIZE-1:0] rdata_q;
  logic [PDATA_SIZE-1:0] mem_q [MEM_DEPTH];

  logic [PADDR_SIZE-1:0] bus_idx, cur_idx;
  logic                  bus_err, cur_err, cur_write;
  logic [StrbW-1:0]      cur_strb;
  logic [PDATA_SIZE-1:0] cur_wdata;
  logic [MemAw-1:0]      mem_addr;
  logic                  accept, abort, go_resp, mem_we, wait_done;
  logic [3:0]            wait_n;
  logic                  unused_pprot;

  assign unused_pprot = ^{PPROT[2], PPROT[0]};

  assign bus_idx = PADDR >> AddrLsb;
  assign bus_err = (32'(bus_idx) >= MEM_DEPTH) ||
                   ((SECURE_UPPER != 0) && (32'(bus_idx) >= MEM_DEPTH / 2) && PPROT[1]);

  // A zero-wait transfer completes at its setup edge, before the latches hold it.
  assign cur_idx   = (state_q == StWait) ? idx_q   : bus_idx;
  assign cur_err   = (state_q == StWait) ? err_q   : bus_err;
  assign cur_write = (state_q == StWait) ? write_q : PWRITE;
  assign cur_strb  = (state_q == StWait) ? strb_q  : PSTRB;
  assign cur_wdata = (state_q == StWait) ? wdata_q : PWDATA;
  assign mem_addr  = cur_idx[MemAw-1:0];

  assign accept  = (state_q != StWait) && PSEL && !PENABLE;
  assign abort   = (state_q == StWait) && !PSEL;
  assign go_resp = (accept && (wait_n == 4'd0)) || ((state_q == StWait) && PSEL && wait_done);
  assign mem_we  = go_resp && cur_write && !cur_err && !PRESET;

  soc_riscv_apb_wait_gen #(
    .WAIT_MODE  (WAIT_MODE),
    .WAIT_STATES(WAIT_STATES)
  ) u_wait_gen (
    .clk_i  (PCLK),
    .rst_i  (PRESET),
    .load_i (accept),
    .clear_i(abort),
    .n_o    (wait_n),
    .done_o (wait_done)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle, StResp: begin
        if (accept) state_d = (wait_n == 4'd0) ? StResp : StWait;
        else        state_d = StIdle;
      end
      StWait: begin
        if (!PSEL)          state_d = StIdle;
        else if (wait_done) state_d = StResp;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      state_q <= StIdle;
      idx_q   <= '0;
      write_q <= 1'b0;
      err_q   <= 1'b0;
      strb_q  <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        idx_q   <= bus_idx;
        write_q <= PWRITE;
        err_q   <= bus_err;
        strb_q  <= PSTRB;
        wdata_q <= PWDATA;
      end
    end
  end

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      ready_q  <= 1'b0;
      slverr_q <= 1'b0;
      rdata_q  <= '0;
    end else begin
      ready_q  <= go_resp;
      slverr_q <= go_resp && cur_err;
      if (go_resp && !cur_write) rdata_q <= cur_err ? '0 : mem_q[mem_addr];
    end
  end

  always_ff @(posedge PCLK) begin
    if (mem_we) begin
      for (int i = 0; i < int'(StrbW); i++) begin
        if (cur_strb[i]) mem_q[mem_addr][8*i +: 8] <= cur_wdata[8*i +: 8];
      end
    end
  end

  assign PREADY  = ready_q;
  assign PSLVERR = slverr_q;
  assign PRDATA  = rdata_q;

endmodule

// File: tb/tb_soc_riscv_apb_slave_mem.sv
// Directed bench for soc_riscv_apb_slave_mem across three configurations sharing one APB bus.
module tb_soc_riscv_apb_slave_mem;

  logic        clk = 1'b0;
  logic        rst;
  logic        psel, penable, pwrite;
  logic [2:0]  pprot;
  logic [9:0]  paddr;
  logic [31:0] pwdata;
  logic [3:0]  pstrb;
  int          cur;

  logic [7:0]  prdata_a;
  logic [31:0] prdata_b;
  logic [15:0] prdata_c;
  logic        rdy_a, rdy_b, rdy_c, err_a, err_b, err_c;
  logic        rdy, slverr;
  logic [31:0] rdata;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  // a: 8-bit, zero wait, secure upper half
  soc_riscv_apb_slave_mem #(
    .PADDR_SIZE(10), .PDATA_SIZE(8), .MEM_DEPTH(256),
    .WAIT_MODE(0), .WAIT_STATES(0), .SECURE_UPPER(1)
  ) u_a (
    .PCLK(clk), .PRESET(rst), .PSEL(psel && (cur == 0)), .PENABLE(penable),
    .PPROT(pprot), .PWRITE(pwrite), .PSTRB(pstrb[0:0]), .PADDR(paddr),
    .PWDATA(pwdata[7:0]), .PRDATA(prdata_a), .PREADY(rdy_a), .PSLVERR(err_a)
  );

  // b: 32-bit, three fixed wait states
  soc_riscv_apb_slave_mem #(
    .PADDR_SIZE(10), .PDATA_SIZE(32), .MEM_DEPTH(256),
    .WAIT_MODE(0), .WAIT_STATES(3), .SECURE_UPPER(0)
  ) u_b (
    .PCLK(clk), .PRESET(rst), .PSEL(psel && (cur == 1)), .PENABLE(penable),
    .PPROT(pprot), .PWRITE(pwrite), .PSTRB(pstrb), .PADDR(paddr),
    .PWDATA(pwdata), .PRDATA(prdata_b), .PREADY(rdy_b), .PSLVERR(err_b)
  );

  // c: 16-bit, random 0..7 wait states
  soc_riscv_apb_slave_mem #(
    .PADDR_SIZE(10), .PDATA_SIZE(16), .MEM_DEPTH(256),
    .WAIT_MODE(1), .WAIT_STATES(7), .SECURE_UPPER(0)
  ) u_c (
    .PCLK(clk), .PRESET(rst), .PSEL(psel && (cur == 2)), .PENABLE(penable),
    .PPROT(pprot), .PWRITE(pwrite), .PSTRB(pstrb[1:0]), .PADDR(paddr),
    .PWDATA(pwdata[15:0]), .PRDATA(prdata_c), .PREADY(rdy_c), .PSLVERR(err_c)
  );

  always_comb begin
    rdy    = rdy_c;
    slverr = err_c;
    rdata  = {16'b0, prdata_c};
    if (cur == 0) begin
      rdy    = rdy_a;
      slverr = err_a;
      rdata  = {24'b0, prdata_a};
    end else if (cur == 1) begin
      rdy    = rdy_b;
      slverr = err_b;
      rdata  = prdata_b;
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Called #1 after a rising edge; returns #1 after the completing edge with the bus idle,
  // so consecutive calls run back-to-back.
  task automatic apb_xfer(input int dut, input logic wr, input logic [9:0] addr,
                          input logic [31:0] wdata, input logic [3:0] strb,
                          input logic [2:0] prot, output logic [31:0] rd,
                          output logic er, output int waits);
    cur     = dut;
    psel    = 1'b1;
    penable = 1'b0;
    pwrite  = wr;
    paddr   = addr;
    pwdata  = wdata;
    pstrb   = strb;
    pprot   = prot;
    @(posedge clk); #1;
    penable = 1'b1;
    waits   = 0;
    while (!rdy && waits < 40) begin
      @(posedge clk); #1;
      waits++;
    end
    if (!rdy) check_eq("ready_timeout", {31'b0, rdy}, 32'd1);
    rd = rdata;
    er = slverr;
    @(posedge clk); #1;
    psel    = 1'b0;
    penable = 1'b0;
  endtask

  logic [31:0] rd;
  logic        er, wr, exp_err, seen_rdy;
  int          wt, idx, max_wt;
  logic [1:0]  st;
  logic [15:0] wd;
  logic [15:0] model [16];

  initial begin
    rst = 1'b1; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    pprot = '0; paddr = '0; pwdata = '0; pstrb = '0; cur = 0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_ready_a", {31'b0, rdy_a}, 32'd0);
    check_eq("rst_ready_b", {31'b0, rdy_b}, 32'd0);
    check_eq("rst_slverr_b", {31'b0, err_b}, 32'd0);
    check_eq("rst_rdata_b", prdata_b, 32'd0);
    check_eq("rst_rdata_c", {16'b0, prdata_c}, 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Zero-wait write/read
    apb_xfer(0, 1'b1, 10'h010, 32'hA5, 4'h1, 3'b000, rd, er, wt);
    check_eq("zw_write_wait", wt, 32'd0);
    check_eq("zw_write_err", {31'b0, er}, 32'd0);
    apb_xfer(0, 1'b0, 10'h010, 32'h0, 4'h0, 3'b000, rd, er, wt);
    check_eq("zw_read_wait", wt, 32'd0);
    check_eq("zw_read_data", rd, 32'hA5);
    check_eq("zw_read_err", {31'b0, er}, 32'd0);

    // Out of range: 0x300 aliases word 0 in its low bits
    apb_xfer(0, 1'b1, 10'h000, 32'h5A, 4'h1, 3'b000, rd, er, wt);
    apb_xfer(0, 1'b0, 10'h300, 32'h0, 4'h0, 3'b000, rd, er, wt);
    check_eq("oor_read_err", {31'b0, er}, 32'd1);
    check_eq("oor_read_data", rd, 32'h0);
    apb_xfer(0, 1'b1, 10'h300, 32'h77, 4'h1, 3'b000, rd, er, wt);
    check_eq("oor_write_err", {31'b0, er}, 32'd1);
    apb_xfer(0, 1'b0, 10'h000, 32'h0, 4'h0, 3'b000, rd, er, wt);
    check_eq("oor_word0_kept", rd, 32'h5A);

    // Secure upper half
    apb_xfer(0, 1'b1, 10'h0F0, 32'h3C, 4'h1, 3'b000, rd, er, wt);
    check_eq("sec_init_err", {31'b0, er}, 32'd0);
    apb_xfer(0, 1'b1, 10'h0F0, 32'hC3, 4'h1, 3'b010, rd, er, wt);
    check_eq("sec_ns_write_err", {31'b0, er}, 32'd1);
    apb_xfer(0, 1'b0, 10'h0F0, 32'h0, 4'h0, 3'b000, rd, er, wt);
    check_eq("sec_ns_write_blocked", rd, 32'h3C);
    apb_xfer(0, 1'b1, 10'h0F0, 32'hC3, 4'h1, 3'b000, rd, er, wt);
    check_eq("sec_s_write_err", {31'b0, er}, 32'd0);
    apb_xfer(0, 1'b0, 10'h0F0, 32'h0, 4'h0, 3'b000, rd, er, wt);
    check_eq("sec_s_readback", rd, 32'hC3);
    apb_xfer(0, 1'b0, 10'h0F0, 32'h0, 4'h0, 3'b010, rd, er, wt);
    check_eq("sec_ns_read_err", {31'b0, er}, 32'd1);
    check_eq("sec_ns_read_data", rd, 32'h0);

    // 32-bit with strobes and three wait states
    apb_xfer(1, 1'b1, 10'h040, 32'h11223344, 4'hF, 3'b000, rd, er, wt);
    check_eq("w3_write1_wait", wt, 32'd3);
    apb_xfer(1, 1'b1, 10'h040, 32'hFFFFFFFF, 4'b0101, 3'b000, rd, er, wt);
    check_eq("w3_write2_wait", wt, 32'd3);
    apb_xfer(1, 1'b0, 10'h040, 32'h0, 4'h0, 3'b000, rd, er, wt);
    check_eq("w3_read_wait", wt, 32'd3);
    check_eq("w3_strobe_data", rd, 32'h11FF33FF);
    apb_xfer(1, 1'b1, 10'h040, 32'h0, 4'h0, 3'b000, rd, er, wt);
    check_eq("nostrb_err", {31'b0, er}, 32'd0);
    apb_xfer(1, 1'b0, 10'h043, 32'h0, 4'h0, 3'b000, rd, er, wt);
    check_eq("nostrb_unchanged", rd, 32'h11FF33FF);

    // PSEL dropped during wait states: no completion, no write
    cur = 1; pwrite = 1'b1; paddr = 10'h040; pwdata = 32'h0; pstrb = 4'hF;
    psel = 1'b1; penable = 1'b0;
    @(posedge clk); #1;
    penable = 1'b1;
    @(posedge clk); #1;
    psel = 1'b0; penable = 1'b0;
    seen_rdy = 1'b0;
    repeat (6) begin
      @(posedge clk); #1;
      seen_rdy |= rdy_b;
    end
    check_eq("abort_no_ready", {31'b0, seen_rdy}, 32'd0);
    apb_xfer(1, 1'b0, 10'h040, 32'h0, 4'h0, 3'b000, rd, er, wt);
    check_eq("abort_no_write", rd, 32'h11FF33FF);

    // Random back-to-back traffic with wait states 0..7
    for (int i = 0; i < 16; i++) begin
      wd = 16'($urandom);
      apb_xfer(2, 1'b1, 10'(i * 2), {16'b0, wd}, 4'b0011, 3'b000, rd, er, wt);
      model[i] = wd;
    end
    max_wt = 0;
    for (int i = 0; i < 1000; i++) begin
      idx = ($urandom_range(0, 9) == 0) ? int'($urandom_range(256, 511))
                                        : int'($urandom_range(0, 15));
      wr  = 1'($urandom_range(0, 1));
      st  = 2'($urandom_range(0, 3));
      wd  = 16'($urandom);
      exp_err = (idx >= 256);
      apb_xfer(2, wr, 10'(idx * 2 + int'($urandom_range(0, 1))), {16'b0, wd}, {2'b0, st},
               3'($urandom_range(0, 7)), rd, er, wt);
      check_eq("rnd_wait_le7", {31'b0, (wt <= 7)}, 32'd1);
      check_eq("rnd_err", {31'b0, er}, {31'b0, exp_err});
      if (wt > max_wt) max_wt = wt;
      if (!wr) begin
        check_eq("rnd_rdata", rd, exp_err ? 32'h0 : {16'b0, model[idx]});
      end else if (!exp_err) begin
        for (int b = 0; b < 2; b++) begin
          if (st[b]) model[idx][8*b +: 8] = wd[8*b +: 8];
        end
      end
    end
    check_eq("rnd_wait_varies", {31'b0, (max_wt > 0)}, 32'd1);

    // Reset during wait states of a write
    apb_xfer(1, 1'b1, 10'h020, 32'hAAAA5555, 4'hF, 3'b000, rd, er, wt);
    cur = 1; pwrite = 1'b1; paddr = 10'h020; pwdata = 32'h12345678; pstrb = 4'hF;
    psel = 1'b1; penable = 1'b0;
    @(posedge clk); #1;
    penable = 1'b1;
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    check_eq("rst_wait_ready", {31'b0, rdy_b}, 32'd0);
    psel = 1'b0; penable = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    apb_xfer(1, 1'b0, 10'h020, 32'h0, 4'h0, 3'b000, rd, er, wt);
    check_eq("rst_write_discarded", rd, 32'hAAAA5555);

    // Reset while PREADY is high clears outputs asynchronously
    cur = 1; pwrite = 1'b0; paddr = 10'h020; psel = 1'b1; penable = 1'b0;
    @(posedge clk); #1;
    penable = 1'b1;
    wt = 0;
    while (!rdy_b && wt < 40) begin
      @(posedge clk); #1;
      wt++;
    end
    check_eq("rst_resp_ready_before", {31'b0, rdy_b}, 32'd1);
    check_eq("rst_resp_data_before", prdata_b, 32'hAAAA5555);
    #2;
    rst = 1'b1;
    #1;
    check_eq("rst_resp_ready_after", {31'b0, rdy_b}, 32'd0);
    check_eq("rst_resp_data_after", prdata_b, 32'h0);
    psel = 1'b0; penable = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
